bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/seq_pkg.sv | 20 ++
 rtl/bit_serializer_if.sv | 24 ++
 rtl/bit_serializer.sv | 89 ++++++++
 tb/tb_bit_serializer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared constants for the serial bit path: serializer FSM encoding, default word width,
// and the state encoding of the downstream 1011 sequence detector.
package seq_pkg;

  localparam int SER_WIDTH_DEFAULT = 8;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_e;

  typedef enum logic [2:0] {
    DET_IDLE  = 3'd0,
    DET_S1    = 3'd1,
    DET_S10   = 3'd2,
    DET_S101  = 3'd3,
    DET_S1011 = 3'd4
  } det_state_e;

endpackage

// File: rtl/bit_serializer_if.sv
// Parallel-in / serial-out bundle: word handshake from upstream, shift enable, serial stream out.
interface bit_serializer_if #(
  parameter int WIDTH = seq_pkg::SER_WIDTH_DEFAULT
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             en;
  logic             out_bit;
  logic             out_valid;
  logic             word_done;

  modport master (
    output in_data, in_valid, en,
    input  in_ready, out_bit, out_valid, word_done
  );

  modport slave (
    input  in_data, in_valid, en,
    output in_ready, out_bit, out_valid, word_done
  );

endinterface

// File: rtl/bit_serializer.sv
// Word-to-bit serializer: one-word hold register feeding a shifter, so the next word waits
// while the current one streams out and back-to-back words leave no gap in the bit stream.
module bit_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH     = SER_WIDTH_DEFAULT,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic             clk,
  input logic             reset,
  bit_serializer_if.slave bus
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  ser_state_e       state;
  ser_state_e       next_state;
  logic [WIDTH-1:0] hold_q;
  logic [WIDTH-1:0] shift_q;
  logic             hold_full;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    bit_idx;
  logic             accept;
  logic             last_bit;
  logic             load;

  // in_ready is !hold_full, so accept and load are mutually exclusive by construction.
  assign accept   = bus.in_valid && !hold_full;
  assign last_bit = (state == SER_SHIFT) && bus.en && (cnt == LAST);
  assign load     = hold_full && ((state == SER_IDLE) || last_bit);
  assign bit_idx  = MSB_FIRST ? (LAST - cnt) : cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SER_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      SER_IDLE:  if (hold_full) next_state = SER_SHIFT;
      SER_SHIFT: if (last_bit && !hold_full) next_state = SER_IDLE;
      default:   next_state = SER_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q    <= '0;
      hold_full <= 1'b0;
      shift_q   <= '0;
      cnt       <= '0;
    end else begin
      if (accept) begin
        hold_q    <= bus.in_data;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end

      // The IDLE->SHIFT transfer does not wait for en; only bit advance does.
      if (load) begin
        shift_q <= hold_q;
        cnt     <= '0;
      end else if (last_bit) begin
        cnt <= '0;
      end else if ((state == SER_SHIFT) && bus.en) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    bus.in_ready  = !hold_full;
    bus.out_valid = 1'b0;
    bus.out_bit   = 1'b0;
    bus.word_done = 1'b0;
    if (state == SER_SHIFT) begin
      bus.out_valid = 1'b1;
      bus.out_bit   = shift_q[bit_idx];
      bus.word_done = bus.en && (cnt == LAST);
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: MSB-first and LSB-first instances side by side.
module tb_bit_serializer;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bit_serializer_if #(.WIDTH(8)) bus0 ();
  bit_serializer_if #(.WIDTH(8)) bus1 ();

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .reset(reset), .bus(bus0));
  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .reset(reset), .bus(bus1));

  typedef struct packed {
    logic b;
    logic done;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   pops[2];
  int   run[2];
  int   last_run[2];
  int   vcnt[2];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic rdy(input int id);
    return (id == 0) ? bus0.in_ready : bus1.in_ready;
  endfunction

  task automatic drive(input int id, input logic v, input logic [7:0] d);
    if (id == 0) begin
      bus0.in_valid = v;
      bus0.in_data  = d;
    end else begin
      bus1.in_valid = v;
      bus1.in_data  = d;
    end
  endtask

  // Monitor: pops one expected bit per valid cycle with en high; a stalled cycle must
  // keep showing the pending bit without word_done.
  task automatic mon(input int id, input logic ov, input logic ob, input logic wd, input logic en_s);
    exp_t e;
    int   sz;
    sz = (id == 0) ? q0.size() : q1.size();
    if (ov) begin
      run[id]++;
      vcnt[id]++;
      chk($sformatf("bit_expected_dut%0d", id), int'(sz != 0), 1);
      if (sz != 0) begin
        e = (id == 0) ? q0[0] : q1[0];
        if (en_s) begin
          if (id == 0) e = q0.pop_front();
          else e = q1.pop_front();
          pops[id]++;
          chk($sformatf("out_bit_dut%0d_n%0d", id, pops[id]), int'(ob), int'(e.b));
          chk($sformatf("word_done_dut%0d_n%0d", id, pops[id]), int'(wd), int'(e.done));
        end else begin
          chk($sformatf("stall_bit_dut%0d", id), int'(ob), int'(e.b));
          chk($sformatf("stall_done_dut%0d", id), int'(wd), 0);
        end
      end
    end else begin
      if (run[id] != 0) last_run[id] = run[id];
      run[id] = 0;
      chk($sformatf("idle_done_dut%0d", id), int'(wd), 0);
      chk($sformatf("idle_bit_dut%0d", id), int'(ob), 0);
    end
  endtask

  always @(negedge clk) mon(0, bus0.out_valid, bus0.out_bit, bus0.word_done, bus0.en);
  always @(negedge clk) mon(1, bus1.out_valid, bus1.out_bit, bus1.word_done, bus1.en);

  // Offer a word until accepted; seq is the hand-computed bit order on the wire.
  task automatic send(input int id, input logic [7:0] w, input logic [7:0] seq, output int waited);
    logic acc;
    exp_t e;
    waited = 0;
    acc    = 1'b0;
    drive(id, 1'b1, w);
    while (!acc && waited < 100) begin
      acc = rdy(id);
      @(posedge clk);
      #1;
      waited++;
    end
    chk($sformatf("accept_dut%0d_%h", id, w), int'(acc), 1);
    if (acc) begin
      for (int i = 7; i >= 0; i--) begin
        e.b    = seq[i];
        e.done = (i == 0);
        if (id == 0) q0.push_back(e);
        else q1.push_back(e);
      end
      chk($sformatf("in_ready_low_after_accept_dut%0d", id), int'(rdy(id)), 0);
    end
  endtask

  task automatic wait_pops(input int id, input int n);
    int c;
    c = 0;
    while (pops[id] < n && c < 200) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk($sformatf("wait_pops_dut%0d", id), int'(pops[id] >= n), 1);
  endtask

  task automatic wait_drain(input int id);
    int   c;
    int   sz;
    logic ov;
    c = 0;
    do begin
      @(negedge clk);
      #1;
      sz = (id == 0) ? q0.size() : q1.size();
      ov = (id == 0) ? bus0.out_valid : bus1.out_valid;
      c++;
    end while ((sz != 0 || ov) && c < 300);
    chk($sformatf("drain_dut%0d", id), int'(sz == 0 && !ov), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t exceeded, expected completion earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int base;
    int v;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    bus0.en = 1'b1;
    bus1.en = 1'b1;
    reset   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(bus0.in_ready), 1);
    chk("rst_out_valid", int'(bus0.out_valid), 0);
    chk("rst_out_bit", int'(bus0.out_bit), 0);
    chk("rst_word_done", int'(bus0.word_done), 0);
    reset = 1'b0;

    // Single word B0, MSB first; accepted at first edge after reset release.
    send(0, 8'hB0, 8'b1011_0000, w);
    drive(0, 1'b0, 8'h00);
    chk("first_accept_wait", w, 1);
    chk("latency_cycle1_valid", int'(bus0.out_valid), 0);
    @(posedge clk);
    #1;
    chk("latency_cycle2_valid", int'(bus0.out_valid), 1);
    chk("latency_first_bit", int'(bus0.out_bit), 1);
    wait_drain(0);
    chk("run_single_b0", last_run[0], 8);

    // Back-to-back B5, 2D, E7 with in_valid held high throughout.
    send(0, 8'hB5, 8'b1011_0101, w);
    send(0, 8'h2D, 8'b0010_1101, w);
    chk("b2b_second_wait", w, 2);
    send(0, 8'hE7, 8'b1110_0111, w);
    chk("b2b_third_wait", w, 8);
    drive(0, 1'b0, 8'h00);
    wait_drain(0);
    chk("run_b2b", last_run[0], 24);

    // en low for 3 cycles while the 4th bit of B0 is presented.
    base = pops[0];
    send(0, 8'hB0, 8'b1011_0000, w);
    drive(0, 1'b0, 8'h00);
    wait_pops(0, base + 3);
    bus0.en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("stall_still_valid", int'(bus0.out_valid), 1);
    bus0.en = 1'b1;
    wait_drain(0);
    chk("run_stall", last_run[0], 11);

    // Reset mid-word with a second word waiting in the hold register.
    base = pops[0];
    send(0, 8'hB5, 8'b1011_0101, w);
    send(0, 8'h2D, 8'b0010_1101, w);
    drive(0, 1'b0, 8'h00);
    wait_pops(0, base + 4);
    chk("pre_reset_hold_full", int'(bus0.in_ready), 0);
    reset = 1'b1;
    q0.delete();
    #1;
    chk("midrst_out_valid", int'(bus0.out_valid), 0);
    chk("midrst_in_ready", int'(bus0.in_ready), 1);
    chk("midrst_out_bit", int'(bus0.out_bit), 0);
    chk("midrst_word_done", int'(bus0.word_done), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    v = vcnt[0];
    repeat (10) @(posedge clk);
    #1;
    chk("no_bits_after_reset", vcnt[0] - v, 0);
    chk("in_ready_after_reset", int'(bus0.in_ready), 1);

    // LSB-first instance: 0D leaves as 1,0,1,1,0,0,0,0.
    send(1, 8'h0D, 8'b1011_0000, w);
    drive(1, 1'b0, 8'h00);
    wait_drain(1);
    chk("run_lsb_0d", last_run[1], 8);
    chk("lsb_bits_popped", pops[1], 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
